// File: rtl/reset_sequencer.sv
// reset_sequencer
// -----------------------------------------------------------------------------
// Supervisory controller for the board reset button.
//
// The raw button is synchronized and then debounced. A press is classified as:
//   - a glitch, which is ignored
//   - a short press, which gives a one-cycle status pulse
//   - a long hold, which asserts every downstream domain reset
// After a long hold, or after power-on, the per-domain resets are released one
// at a time, bit 0 first, with GAP_CYCLES clocks between successive releases.
//
// Optional feature, controlled by the macro RSTSEQ_SOFT_REQ_EN:
//   When the macro is defined, the block gets an extra soft_req input. A
//   soft_req seen in IDLE forces a full reset cycle, exactly as a long hold
//   would.
//
// Ports:
//   clk          in   system clock; all logic runs on the rising edge
//   reset_n      in   asynchronous active-low reset; starts the power-on
//                     release sequence
//   btn          in   raw button, active high, asynchronous to clk
//   soft_req     in   (RSTSEQ_SOFT_REQ_EN only) synchronous reset request,
//                     honoured in IDLE
//   rst_out      out  per-domain resets, active high; bit 0 is released first
//   short_press  out  one-cycle pulse for each valid short press
//   busy         out  high while the domain resets are asserted or being
//                     released
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int N_DOMAINS       = 3,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 5000000,
  parameter int GAP_CYCLES      = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn,
`ifdef RSTSEQ_SOFT_REQ_EN
  input  logic                 soft_req,
`endif
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 short_press,
  output logic                 busy
);

  localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_DH > GAP_CYCLES) ? MAX_DH : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int IDX_W   = $clog2(N_DOMAINS) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    PRESSED  = 3'd2,
    ASSERT   = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next, cnt_inc;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [N_DOMAINS-1:0]   rst_next, idx_bit;
  logic                   short_next, busy_next;
  logic                   btn_meta, btn_s;
  logic                   soft_go;

`ifdef RSTSEQ_SOFT_REQ_EN
  assign soft_go = soft_req;
`else
  assign soft_go = 1'b0;
`endif

  // The counter saturates rather than wraps.
  // This keeps a very long stay in one state from aliasing onto a threshold.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // One-hot mask that selects the domain due for release next.
  assign idx_bit = N_DOMAINS'(1) << idx;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
    end
  end

  // State and output registers.
  // Reset drops straight into the release sequence, so power-on releases the
  // domains in order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASE;
      cnt         <= '0;
      idx         <= '0;
      rst_out     <= '1;
      short_press <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      rst_out     <= rst_next;
      short_press <= short_next;
      busy        <= busy_next;
    end
  end

  // Next-state and next-output logic.
  // Every output is computed from the next state, so each output is a flop and
  // changes on the same edge as the transition that causes it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt_inc;
    idx_next   = idx;
    rst_next   = rst_out;
    short_next = 1'b0;

    case (state)
      IDLE: begin
        rst_next = '0;
        if (soft_go) begin
          state_next = ASSERT;
          rst_next   = '1;
        end else if (btn_s) begin
          state_next = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_next = PRESSED;
        end
      end

      PRESSED: begin
        // The hold threshold is tested first.
        // A release that lands on the qualifying edge is still a long hold.
        if (cnt == HOLD_LAST) begin
          state_next = ASSERT;
          rst_next   = '1;
        end else if (!btn_s) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end

      ASSERT: begin
        rst_next = '1;
        if (!btn_s) begin
          state_next = RELEASE;
          idx_next   = '0;
        end
      end

      RELEASE: begin
        if (cnt == GAP_LAST) begin
          rst_next = rst_out & ~idx_bit;
          if (idx == IDX_LAST) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next   = idx + IDX_W'(1);
            cnt_next   = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        idx_next   = '0;
        rst_next   = '0;
      end
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end

    busy_next = (state_next == ASSERT) || (state_next == RELEASE);
  end

endmodule
